// File: rtl/psk_frame_sched.sv
// Frame scheduler: preamble + sync word + BPSK/QPSK payload + idle gap, paced by modulator strobes.
// Registered outputs; one symbol per m_tready handshake, byte fetched only when the payload register is empty.
module psk_frame_sched #(
  parameter int          PRE_LEN   = 32,
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int          GAP_SYM   = 16,
  parameter int          BYTES     = 1
) (
  input  logic               clk_16M384,
  input  logic               rst_16M384,
  input  logic               cfg_enable,
  input  logic               cfg_is_bpsk,
  input  logic [7:0]         s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [BYTES*8-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               m_tuser,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SYNC, PAY, GAP} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_SYM - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  sync_q, sync_d;
  logic [2:0]  sym_q, sym_d;
  logic        mode_q, mode_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        full_q, full_d;
  logic        vld_q, vld_d;
  logic [1:0]  dat_q, dat_d;
  logic        user_q, user_d;
  logic        tlast_q, tlast_d;
  logic        done_q, done_d;
  logic        under_q, under_d;
  logic        hs;
  logic [2:0]  sym_last;

  // idx counts symbols within the byte, MSB first; QPSK takes bit pairs as {I,Q}
  function automatic logic [1:0] pay_sym(input logic [7:0] b, input logic [2:0] idx,
                                         input logic bpsk);
    if (bpsk) return {b[3'd7 - idx], b[3'd7 - idx]};
    return {b[3'd7 - {idx[1:0], 1'b0}], b[3'd6 - {idx[1:0], 1'b0}]};
  endfunction

  assign hs       = vld_q && m_tready;
  assign sym_last = mode_q ? 3'd7 : 3'd3;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    sym_d   = sym_q;
    mode_d  = mode_q;
    byte_d  = byte_q;
    last_d  = last_q;
    full_d  = full_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    user_d  = user_q;
    tlast_d = tlast_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_enable && s_tvalid) begin
          state_d = PRE;
          mode_d  = cfg_is_bpsk;
          cnt_d   = 8'd0;
          vld_d   = 1'b1;
          dat_d   = 2'b11;
          user_d  = 1'b1;
          tlast_d = 1'b0;
        end
      end
      PRE: begin
        if (hs) begin
          if (cnt_q == PRE_LAST) begin
            state_d = SYNC;
            sync_d  = 4'd0;
            dat_d   = {2{SYNC_WORD[15]}};
          end else begin
            cnt_d = cnt_q + 8'd1;
            dat_d = {2{cnt_q[0]}};
          end
        end
      end
      SYNC: begin
        if (hs) begin
          if (sync_q == 4'd15) begin
            state_d = PAY;
            vld_d   = 1'b0;
            full_d  = 1'b0;
            user_d  = mode_q;
          end else begin
            sync_d = sync_q + 4'd1;
            dat_d  = {2{SYNC_WORD[4'd14 - sync_q]}};
          end
        end
      end
      PAY: begin
        if (!full_q) begin
          // a strobe with no symbol ready is a lost slot, even if a byte lands this cycle
          if (m_tready) under_d = 1'b1;
          if (s_tvalid) begin
            full_d  = 1'b1;
            byte_d  = s_tdata;
            last_d  = s_tlast;
            sym_d   = 3'd0;
            vld_d   = 1'b1;
            dat_d   = pay_sym(s_tdata, 3'd0, mode_q);
            user_d  = mode_q;
            tlast_d = 1'b0;
          end
        end else if (hs) begin
          if (sym_q == sym_last) begin
            full_d  = 1'b0;
            vld_d   = 1'b0;
            tlast_d = 1'b0;
            if (last_q) begin
              state_d = GAP;
              cnt_d   = 8'd0;
            end
          end else begin
            sym_d   = sym_q + 3'd1;
            dat_d   = pay_sym(byte_q, sym_q + 3'd1, mode_q);
            tlast_d = last_q && ((sym_q + 3'd1) == sym_last);
          end
        end
      end
      GAP: begin
        if (m_tready) begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sync_q  <= 4'd0;
      sym_q   <= 3'd0;
      mode_q  <= 1'b0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= 2'b00;
      user_q  <= 1'b0;
      tlast_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      sym_q   <= sym_d;
      mode_q  <= mode_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      full_q  <= full_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      user_q  <= user_d;
      tlast_q <= tlast_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  assign s_tready   = (state_q == PAY) && !full_q;
  assign busy       = (state_q != IDLE);
  assign m_tvalid   = vld_q;
  assign m_tdata    = {{(BYTES*8-2){1'b0}}, dat_q};
  assign m_tuser    = user_q;
  assign m_tlast    = tlast_q;
  assign frame_done = done_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_psk_frame_sched.sv
// Randomized frame traffic against a frame-level reference model; a negedge monitor scores every symbol handshake.
module tb_psk_frame_sched;

  localparam int          PRE_LEN = 32;
  localparam int          GAP_SYM = 16;
  localparam int          TO      = 4000;
  localparam logic [15:0] SW      = 16'hEB90;

  logic       clk_16M384 = 1'b0;
  logic       rst_16M384 = 1'b0;
  logic       cfg_enable = 1'b0;
  logic       cfg_is_bpsk = 1'b0;
  logic [7:0] s_tdata = 8'd0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tlast;
  logic       m_tuser;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  psk_frame_sched dut (
    .clk_16M384 (clk_16M384),
    .rst_16M384 (rst_16M384),
    .cfg_enable (cfg_enable),
    .cfg_is_bpsk(cfg_is_bpsk),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk_16M384 = ~clk_16M384;

  // modulator: one strobe every 16 clocks, free running
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk_16M384);
      #1;
      ph = (ph + 1) % 16;
      m_tready = (ph == 0);
    end
  end

  typedef struct packed {logic [1:0] d; logic u; logic l;} sym_t;

  sym_t       sb_q[$];
  int         len_q[$];
  int         checks = 0, passes = 0;
  int         hs_total = 0, under_seen = 0, done_cnt = 0;
  int         exp_under = 0, exp_frames = 0;
  logic [7:0] pkt [8];
  int         gap [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic flag_fail(input string name);
    checks++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // reference: expected symbol stream and symbol count of one frame
  task automatic push_frame(input bit mode, input int n);
    sym_t       e;
    logic [7:0] b;
    logic [15:0] sw;
    sw = SW;
    for (int i = 0; i < PRE_LEN; i++) begin
      e.d = (i % 2 == 0) ? 2'b11 : 2'b00; e.u = 1'b1; e.l = 1'b0;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      e.d = {sw[15-i], sw[15-i]}; e.u = 1'b1; e.l = 1'b0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      b = pkt[k];
      if (mode) begin
        for (int j = 0; j < 8; j++) begin
          e.d = {b[7-j], b[7-j]}; e.u = 1'b1; e.l = (k == n-1) && (j == 7);
          sb_q.push_back(e);
        end
      end else begin
        for (int j = 0; j < 4; j++) begin
          e.d = {b[7-2*j], b[6-2*j]}; e.u = 1'b0; e.l = (k == n-1) && (j == 3);
          sb_q.push_back(e);
        end
      end
    end
    len_q.push_back(PRE_LEN + 16 + n * (mode ? 8 : 4));
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < TO; t++) begin
      if (s_tready) begin ok = 1'b1; break; end
      @(negedge clk_16M384);
    end
    if (!ok) begin flag_fail("accept_timeout"); s_tvalid = 1'b0; return; end
    @(posedge clk_16M384);
    #1;
    s_tvalid = 1'b0;
  endtask

  // byte k>0 is held back gap[k] clocks after the register empties; strobes at
  // empty+16m up to and including the fetch edge are lost slots
  task automatic send_frame(input bit mode, input int n);
    bit ok;
    cfg_is_bpsk = mode;
    push_frame(mode, n);
    for (int k = 1; k < n; k++) exp_under += (gap[k] + 1) / 16;
    s_tdata = pkt[0]; s_tlast = (n == 1); s_tvalid = 1'b1;
    wait_accept(ok);
    if (!ok) return;
    cfg_is_bpsk = ~mode;
    for (int k = 1; k < n; k++) begin
      ok = 1'b0;
      for (int t = 0; t < TO; t++) begin
        @(negedge clk_16M384);
        if (s_tready) begin ok = 1'b1; break; end
      end
      if (!ok) begin flag_fail("empty_timeout"); return; end
      if (gap[k] > 0) begin
        repeat (gap[k]) @(posedge clk_16M384);
        #1;
      end
      s_tdata = pkt[k]; s_tlast = (k == n-1); s_tvalid = 1'b1;
      wait_accept(ok);
      if (!ok) return;
    end
    s_tlast = 1'b0;
    exp_frames++;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3*TO; t++) begin
      @(negedge clk_16M384);
      if (sb_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) flag_fail("idle_timeout");
    repeat (2) @(negedge clk_16M384);
  endtask

  // monitor
  int  frame_hs = 0, gap_pulses = 0, b2b_cnt = 0;
  bit  in_gap = 0, b2b_wait = 0;
  always @(negedge clk_16M384) begin
    sym_t e;
    if (rst_16M384) begin
      frame_hs = 0; gap_pulses = 0; in_gap = 0; b2b_wait = 0;
    end else begin
      if (frame_done) begin
        done_cnt++;
        check("gap_slots", gap_pulses, GAP_SYM);
        if (len_q.size() > 0) check("frame_symbols", frame_hs, len_q.pop_front());
        else flag_fail("unexpected_frame_done");
        frame_hs = 0; in_gap = 0;
        if (sb_q.size() > 0) begin b2b_wait = 1; b2b_cnt = 0; end
      end else if (b2b_wait) begin
        b2b_cnt++;
        if (m_tvalid) begin
          b2b_wait = 0;
          if (b2b_cnt <= 2) begin checks++; passes++; end
          else check("b2b_start_clocks", b2b_cnt, 2);
        end else if (b2b_cnt > 2) begin
          b2b_wait = 0;
          flag_fail("b2b_start_late");
        end
      end
      if (underrun) under_seen++;
      if (m_tvalid && m_tready) begin
        hs_total++;
        frame_hs++;
        if (sb_q.size() == 0) flag_fail("unexpected_symbol");
        else begin
          e = sb_q.pop_front();
          check("sym_data", int'(m_tdata), int'(e.d));
          check("sym_user", int'(m_tuser), int'(e.u));
          check("sym_last", int'(m_tlast), int'(e.l));
          if (e.l) begin in_gap = 1; gap_pulses = 0; end
        end
      end else if (m_tready && in_gap) begin
        gap_pulses++;
      end
    end
  end

  initial begin
    int  base, ub;
    bit  bad, ok;
    #1 rst_16M384 = 1'b1;
    repeat (3) @(posedge clk_16M384);
    #1 rst_16M384 = 1'b0;
    @(negedge clk_16M384);
    check("rst_m_tvalid", int'(m_tvalid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_s_tready", int'(s_tready), 0);
    check("rst_m_tdata", int'(m_tdata), 0);
    check("rst_flags", int'({frame_done, underrun, m_tlast}), 0);
    cfg_enable = 1'b1;

    for (int k = 0; k < 8; k++) gap[k] = 0;
    pkt[0] = 8'hA5; pkt[1] = 8'h3C;
    send_frame(1'b0, 2);
    send_frame(1'b1, 2);
    wait_idle();

    ub = under_seen;
    gap[1] = 40;
    send_frame(1'b0, 2);
    wait_idle();
    check("withhold_underruns", under_seen - ub, 2);
    gap[1] = 0;

    // asynchronous reset in the middle of the sync word
    push_frame(1'b1, 1);
    pkt[0] = 8'hC3;
    base = hs_total;
    s_tdata = 8'hC3; s_tlast = 1'b1; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < TO; t++) begin
      @(negedge clk_16M384);
      if (hs_total >= base + PRE_LEN + 4) begin ok = 1'b1; break; end
    end
    if (!ok) flag_fail("sync_reach_timeout");
    @(posedge clk_16M384);
    #3 rst_16M384 = 1'b1;
    #1;
    check("arst_m_tvalid", int'(m_tvalid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_m_tdata", int'(m_tdata), 0);
    check("arst_m_tuser", int'(m_tuser), 0);
    check("arst_s_tready", int'(s_tready), 0);
    sb_q.delete();
    len_q.delete();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) @(posedge clk_16M384);
    #1 rst_16M384 = 1'b0;

    // disabled while data waits: no frame may start
    cfg_enable = 1'b0;
    s_tdata = 8'h55; s_tvalid = 1'b1;
    base = hs_total;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk_16M384);
      if (busy || s_tready || m_tvalid) bad = 1'b1;
    end
    check("disabled_stays_idle", int'(bad), 0);
    check("disabled_no_handshake", hs_total - base, 0);
    s_tvalid = 1'b0;
    @(posedge clk_16M384);
    #1 cfg_enable = 1'b1;

    // random back-to-back frames
    for (int f = 0; f < 8; f++) begin
      int n, sel;
      bit mode;
      n = $urandom_range(1, 4);
      mode = $urandom_range(0, 1);
      for (int k = 0; k < n; k++) begin
        pkt[k] = 8'($urandom);
        sel = $urandom_range(0, 5);
        case (sel)
          0, 1:    gap[k] = 0;
          2:       gap[k] = 15;
          3:       gap[k] = 31;
          4:       gap[k] = 40;
          default: gap[k] = $urandom_range(0, 50);
        endcase
      end
      send_frame(mode, n);
    end
    wait_idle();

    check("underrun_total", under_seen, exp_under);
    check("frames_done", done_cnt, exp_frames);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/psk_frame_sched.md
Name: psk_frame_sched

Overview:
- Frame scheduler that sequences the PSK modulator's symbol AXIS input at the 1.024M symbol rate.
- Wraps each payload packet from the 16.384M byte FIFO into a frame of BPSK preamble, BPSK 16-bit sync word, payload (BPSK or QPSK) and an idle guard gap.
- Payload bytes are split into per-symbol 2-bit words.
- Sits between the TX byte FIFO and the modulator; all timing is paced by the modulator's m_tready pulses (one per symbol period).

Parameters:
- PRE_LEN, 32, preamble length in symbols (1..255).
- SYNC_WORD, 16'hEB90, sync word, sent MSB first, BPSK.
- GAP_SYM, 16, guard symbols (tvalid low) after each frame (1..255).
- BYTES, 1, m_tdata width in bytes; only bits [1:0] carry data, upper bits 0.

Ports:
- clk_16M384  in  1  system clock.
- rst_16M384  in  1  Reset.
- cfg_enable  in  1  allow new frames; sampled only in IDLE.
- cfg_is_bpsk  in  1  payload modulation; latched at frame start.
- s_tdata  in  8  payload byte from FIFO.
- s_tvalid  in  1  byte valid.
- s_tready  out  1  byte accepted when s_tvalid && s_tready.
- s_tlast  in  1  last byte of packet.
- m_tdata  out  BYTES*8  symbol to modulator; [1]=I bit, [0]=Q bit.
- m_tvalid  out  1  symbol valid.
- m_tready  in  1  modulator symbol strobe, one-cycle pulse per 16 clocks.
- m_tlast  out  1  last payload symbol of frame.
- m_tuser  out  1  is_bpsk for current symbol.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of gap.
- underrun  out  1  one-cycle pulse, payload symbol slot missed.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Outputs go to 0 immediately; state goes to IDLE and all counters/registers clear.
  - Any frame in progress is discarded; no partial-frame resume.
- Outputs are registered. A symbol handshake is m_tvalid && m_tready.
  - m_tdata, m_tuser and m_tlast are held stable until the handshake.
  - The next symbol appears the cycle after the handshake.
- Only while m_tvalid is low, m_tready pulses count symbol slots.
- States: IDLE, PRE, SYNC, PAY, GAP.
- IDLE:
  - m_tvalid=0.
  - If cfg_enable && s_tvalid: latch mode_bpsk=cfg_is_bpsk and go to PRE with m_tvalid=1.
- PRE:
  - PRE_LEN symbols, m_tuser=1.
  - Bit pattern is 1,0,1,0,... starting with 1. BPSK drives m_tdata[1:0]={b,b}.
  - After the handshake of the last preamble symbol, go to SYNC.
- SYNC:
  - 16 symbols, m_tuser=1, SYNC_WORD bit 15 first, same {b,b} mapping.
  - After the 16th handshake, go to PAY with the byte register empty.
- PAY:
  - m_tuser=mode_bpsk.
  - s_tready=1 while in PAY and the byte register is empty. A fetch loads the byte and its tlast into the register, and m_tvalid=1 the next cycle.
  - BPSK: 8 symbols per byte, MSB first, {b,b}.
  - QPSK: 4 symbols per byte, pairs {b7,b6},{b5,b4},{b3,b2},{b1,b0} as {I,Q}.
  - The register empties on the handshake of the byte's final symbol. A new fetch may occur the following cycle.
  - m_tlast=1 only on the final symbol of a byte carrying tlast. After its handshake, go to GAP.
  - Underrun: register empty and m_tready high in PAY.
    - Pulse underrun; m_tvalid stays 0.
    - No symbol is emitted and the frame continues when data arrives.
- GAP:
  - m_tvalid=0; count GAP_SYM m_tready pulses.
  - On the last pulse, pulse frame_done and go to IDLE.
  - A new frame may start in the next IDLE cycle.
- Simultaneous events:
  - A fetch in the same cycle as the modulator strobe: the strobe counts as underrun; the byte is used in the next slot.
  - cfg_enable and cfg_is_bpsk changes mid-frame are ignored.
- s_tready is never high outside PAY.
- Counters: preamble/gap counters 8-bit, sync counter 4-bit, symbol-in-byte counter 3-bit. All wrap-free: they reload at state entry.

Test Plan:
- Reset then cfg_enable=1, cfg_is_bpsk=0, packet {8'hA5, 8'h3C(last)}, modulator model pulsing m_tready every 16 clocks.
  - Expect 32 preamble symbols 11,00,11,..., then sync EB90 as 11,11,11,00,11,...
  - Then QPSK payload 10,10,01,01,00,11,11,00 with tlast on the 8th payload symbol.
  - Then 16 idle slots, then a frame_done pulse.
- Same packet with cfg_is_bpsk=1: 16 BPSK payload symbols, A5 → 11,00,11,00,00,11,00,11; m_tuser=1 throughout; tlast on the 16th.
- Withhold the second byte for 40 clocks: 2 underrun pulses, no m_tvalid in those slots, then resume with correct bits and tlast.
- Assert rst_16M384 mid-SYNC asynchronously: outputs 0 and busy=0 without a clock edge; s_tready stays 0 until a new frame reaches PAY.
- Toggle cfg_is_bpsk mid-payload: no effect. cfg_enable=0 in IDLE with s_tvalid=1: stays IDLE, no handshakes.
- Back-to-back packets: second preamble starts ≤2 clocks after frame_done; symbol count per frame = 32+16+payload symbols.
